// File: rtl/router_pkg.sv
// Shared router constants and the output-arbiter state encoding.
package router_pkg;

    localparam int NUM_PORTS    = 8;
    localparam int PORT_IDX_W   = 3;
    localparam int HDR_BITS     = 4;
    localparam int PAD_BITS     = 10;
    localparam int PAYLOAD_BITS = 32;
    localparam int PKT_BITS     = HDR_BITS + PAD_BITS + PAYLOAD_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/router_out_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
interface router_out_arbiter_if
    import router_pkg::*;
#(
    parameter int NUM_IN = NUM_PORTS,
    parameter int IDX_W  = PORT_IDX_W
);
    logic [NUM_IN-1:0] req_i;
    logic [NUM_IN-1:0] pkt_done_i;
    logic [NUM_IN-1:0] gnt_o;
    logic [IDX_W-1:0]  gnt_idx_o;
    logic              busy_o;
    logic              timeout_o;

    // Input-port side: raises requests and end-of-packet pulses.
    modport master (
        output req_i,
        output pkt_done_i,
        input  gnt_o,
        input  gnt_idx_o,
        input  busy_o,
        input  timeout_o
    );

    // Arbiter side.
    modport slave (
        input  req_i,
        input  pkt_done_i,
        output gnt_o,
        output gnt_idx_o,
        output busy_o,
        output timeout_o
    );
endinterface

// File: rtl/router_out_arbiter_rr_pick.sv
// Rotating priority encoder: first requester strictly after ptr, with wrap.
// The candidate index wraps by natural overflow, so NUM_IN must be 2**IDX_W.
module rr_pick #(
    parameter int NUM_IN = 8,
    parameter int IDX_W  = 3
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_IN-1:0] win_onehot,
    output logic [IDX_W-1:0]  win_idx,
    output logic              any_valid
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan ptr+1 .. ptr+NUM_IN; the pointer itself has lowest priority.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                found            = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port scheduler: round-robin grant held per packet, watchdog,
// and a one-cycle gap between packets.
//
//   state | meaning
//   IDLE  | no grant; arbitrate among requesters this cycle
//   GRANT | winner owns the crossbar; watchdog running
//   GAP   | one dead cycle so the output frame returns high
//
// TIMEOUT must exceed a full packet (PKT_BITS) or the watchdog would cut
// legal traffic.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int NUM_IN  = NUM_PORTS,
    parameter int IDX_W   = PORT_IDX_W,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset_n,
    router_out_arbiter_if.slave arb
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_nxt;
    logic [WD_W-1:0]   wd_q, wd_nxt;
    logic [IDX_W-1:0]  ptr_q, ptr_nxt;
    logic [IDX_W-1:0]  idx_q, idx_nxt;
    logic [NUM_IN-1:0] win_q, win_nxt;
    logic              timeout_q, timeout_nxt;

    logic [NUM_IN-1:0] pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic              win_done, win_drop, wd_expire;
    logic [NUM_IN-1:0] gnt;
    logic              busy;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req        (arb.req_i),
        .ptr        (ptr_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .any_valid  (pick_any)
    );

    // Only the current winner's request and done pulse matter.
    assign win_done  = |(arb.pkt_done_i & win_q);
    assign win_drop  = ~|(arb.req_i & win_q);
    assign wd_expire = (wd_q == WD_LAST);

    // State, watchdog, round-robin pointer and winner registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wd_q      <= '0;
            ptr_q     <= IDX_W'(NUM_IN - 1);
            idx_q     <= '0;
            win_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            wd_q      <= wd_nxt;
            ptr_q     <= ptr_nxt;
            idx_q     <= idx_nxt;
            win_q     <= win_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, release on done/drop/expiry, one-cycle GAP.
    always_comb begin
        state_nxt   = state_q;
        wd_nxt      = wd_q;
        ptr_nxt     = ptr_q;
        idx_nxt     = idx_q;
        win_nxt     = win_q;
        timeout_nxt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick_idx;
                    win_nxt   = pick_onehot;
                    wd_nxt    = '0;
                end
            end
            GRANT: begin
                wd_nxt = wd_q + WD_W'(1);
                if (win_done || win_drop || wd_expire) begin
                    state_nxt   = GAP;
                    ptr_nxt     = idx_q;
                    // A packet that ends on the expiry cycle is a normal release.
                    timeout_nxt = wd_expire && !win_done && !win_drop;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs: grant only while in GRANT, so reset drops it asynchronously.
    always_comb begin
        gnt  = '0;
        busy = 1'b0;
        if (state_q == GRANT) begin
            gnt  = win_q;
            busy = 1'b1;
        end
    end

    assign arb.gnt_o     = gnt;
    assign arb.busy_o    = busy;
    assign arb.gnt_idx_o = idx_q;
    assign arb.timeout_o = timeout_q;

    // More than one grant at a time would short two inputs onto the crossbar.
    a_gnt_onehot0: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(gnt));

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter.
module tb_router_out_arbiter;

    logic clock;
    logic reset_n;
    int   compared;
    int   mismatched;

    router_out_arbiter_if #(.NUM_IN(8), .IDX_W(3)) arb_if ();

    router_out_arbiter #(
        .NUM_IN  (8),
        .IDX_W   (3),
        .TIMEOUT (64)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .arb     (arb_if)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        arb_if.req_i      = '0;
        arb_if.pkt_done_i = '0;
        reset_n           = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Called on the first grant cycle; pulses done on grant+cycles, returns in GAP.
    task automatic hold_and_done(input int idx, input int cycles);
        repeat (cycles) tick();
        arb_if.pkt_done_i = 8'(32'd1 << idx);
        tick();
        arb_if.pkt_done_i = '0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL reset_gnt: got %h expected %h", arb_if.gnt_o, 8'h00); end
        compared++; if (arb_if.gnt_idx_o !== 3'd0) begin mismatched++; $display("FAIL reset_idx: got %0d expected %0d", arb_if.gnt_idx_o, 0); end
        compared++; if (arb_if.busy_o !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected %b", arb_if.busy_o, 1'b0); end
        compared++; if (arb_if.timeout_o !== 1'b0) begin mismatched++; $display("FAIL reset_timeout: got %b expected %b", arb_if.timeout_o, 1'b0); end
        tick();
        compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL reset_idle_nogrant: got %h expected %h", arb_if.gnt_o, 8'h00); end
    endtask

    task automatic test_single();
        do_reset();
        arb_if.req_i = 8'h01;
        tick();
        compared++; if (arb_if.gnt_o !== 8'h01) begin mismatched++; $display("FAIL single_gnt_first: got %h expected %h", arb_if.gnt_o, 8'h01); end
        compared++; if (arb_if.busy_o !== 1'b1) begin mismatched++; $display("FAIL single_busy: got %b expected %b", arb_if.busy_o, 1'b1); end
        compared++; if (arb_if.gnt_idx_o !== 3'd0) begin mismatched++; $display("FAIL single_idx: got %0d expected %0d", arb_if.gnt_idx_o, 0); end
        repeat (45) tick();
        compared++; if (arb_if.gnt_o !== 8'h01) begin mismatched++; $display("FAIL single_gnt_last: got %h expected %h", arb_if.gnt_o, 8'h01); end
        arb_if.pkt_done_i = 8'h01;
        tick();
        arb_if.pkt_done_i = 8'h00;
        arb_if.req_i      = 8'h00;
        compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL single_gap_gnt: got %h expected %h", arb_if.gnt_o, 8'h00); end
        compared++; if (arb_if.busy_o !== 1'b0) begin mismatched++; $display("FAIL single_gap_busy: got %b expected %b", arb_if.busy_o, 1'b0); end
        compared++; if (arb_if.timeout_o !== 1'b0) begin mismatched++; $display("FAIL single_gap_timeout: got %b expected %b", arb_if.timeout_o, 1'b0); end
        compared++; if (arb_if.gnt_idx_o !== 3'd0) begin mismatched++; $display("FAIL single_idx_hold: got %0d expected %0d", arb_if.gnt_idx_o, 0); end
        tick();
        compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL single_idle_gnt: got %h expected %h", arb_if.gnt_o, 8'h00); end
    endtask

    task automatic test_round_robin(input logic [7:0] req, input int n);
        int order[9];
        for (int k = 0; k < 9; k++) order[k] = k % n;
        do_reset();
        arb_if.req_i = req;
        tick();
        for (int k = 0; k <= n; k++) begin
            compared++; if (arb_if.gnt_o !== 8'(32'd1 << order[k])) begin mismatched++; $display("FAIL rr_gnt[%0d]: got %h expected %h", k, arb_if.gnt_o, 8'(32'd1 << order[k])); end
            compared++; if (arb_if.gnt_idx_o !== 3'(order[k])) begin mismatched++; $display("FAIL rr_idx[%0d]: got %0d expected %0d", k, arb_if.gnt_idx_o, order[k]); end
            hold_and_done(order[k], 45);
            compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL rr_gap[%0d]: got %h expected %h", k, arb_if.gnt_o, 8'h00); end
            tick();
            compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL rr_idle[%0d]: got %h expected %h", k, arb_if.gnt_o, 8'h00); end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        arb_if.req_i = 8'h40;
        tick();
        compared++; if (arb_if.gnt_o !== 8'h40) begin mismatched++; $display("FAIL wrap_gnt6: got %h expected %h", arb_if.gnt_o, 8'h40); end
        hold_and_done(6, 45);
        arb_if.req_i = 8'h00;
        tick();
        arb_if.req_i = 8'h81;
        tick();
        compared++; if (arb_if.gnt_o !== 8'h80) begin mismatched++; $display("FAIL wrap_gnt7: got %h expected %h", arb_if.gnt_o, 8'h80); end
        compared++; if (arb_if.gnt_idx_o !== 3'd7) begin mismatched++; $display("FAIL wrap_idx7: got %0d expected %0d", arb_if.gnt_idx_o, 7); end
        hold_and_done(7, 45);
        arb_if.req_i = 8'h01;
        tick();
        tick();
        compared++; if (arb_if.gnt_o !== 8'h01) begin mismatched++; $display("FAIL wrap_gnt0: got %h expected %h", arb_if.gnt_o, 8'h01); end
    endtask

    task automatic test_watchdog();
        do_reset();
        arb_if.req_i = 8'h04;
        tick();
        compared++; if (arb_if.gnt_o !== 8'h04) begin mismatched++; $display("FAIL wd_gnt2: got %h expected %h", arb_if.gnt_o, 8'h04); end
        arb_if.req_i = 8'h0C;
        repeat (63) tick();
        compared++; if (arb_if.gnt_o !== 8'h04) begin mismatched++; $display("FAIL wd_hold_last: got %h expected %h", arb_if.gnt_o, 8'h04); end
        compared++; if (arb_if.timeout_o !== 1'b0) begin mismatched++; $display("FAIL wd_early_pulse: got %b expected %b", arb_if.timeout_o, 1'b0); end
        tick();
        compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL wd_revoked: got %h expected %h", arb_if.gnt_o, 8'h00); end
        compared++; if (arb_if.busy_o !== 1'b0) begin mismatched++; $display("FAIL wd_busy: got %b expected %b", arb_if.busy_o, 1'b0); end
        compared++; if (arb_if.timeout_o !== 1'b1) begin mismatched++; $display("FAIL wd_pulse: got %b expected %b", arb_if.timeout_o, 1'b1); end
        tick();
        compared++; if (arb_if.timeout_o !== 1'b0) begin mismatched++; $display("FAIL wd_pulse_width: got %b expected %b", arb_if.timeout_o, 1'b0); end
        tick();
        compared++; if (arb_if.gnt_o !== 8'h08) begin mismatched++; $display("FAIL wd_next_gnt: got %h expected %h", arb_if.gnt_o, 8'h08); end
        compared++; if (arb_if.gnt_idx_o !== 3'd3) begin mismatched++; $display("FAIL wd_next_idx: got %0d expected %0d", arb_if.gnt_idx_o, 3); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        arb_if.req_i = 8'h01;
        tick();
        repeat (63) tick();
        arb_if.pkt_done_i = 8'h01;
        tick();
        arb_if.pkt_done_i = 8'h00;
        arb_if.req_i      = 8'h00;
        compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL sim_gnt: got %h expected %h", arb_if.gnt_o, 8'h00); end
        compared++; if (arb_if.timeout_o !== 1'b0) begin mismatched++; $display("FAIL sim_timeout: got %b expected %b", arb_if.timeout_o, 1'b0); end
        tick();
        compared++; if (arb_if.timeout_o !== 1'b0) begin mismatched++; $display("FAIL sim_timeout_idle: got %b expected %b", arb_if.timeout_o, 1'b0); end
        compared++; if (arb_if.busy_o !== 1'b0) begin mismatched++; $display("FAIL sim_busy_idle: got %b expected %b", arb_if.busy_o, 1'b0); end
    endtask

    task automatic test_req_drop();
        do_reset();
        arb_if.req_i = 8'h06;
        tick();
        compared++; if (arb_if.gnt_o !== 8'h02) begin mismatched++; $display("FAIL drop_gnt1: got %h expected %h", arb_if.gnt_o, 8'h02); end
        arb_if.pkt_done_i = 8'h04;
        tick();
        arb_if.pkt_done_i = 8'h00;
        compared++; if (arb_if.gnt_o !== 8'h02) begin mismatched++; $display("FAIL drop_other_done: got %h expected %h", arb_if.gnt_o, 8'h02); end
        arb_if.req_i = 8'h04;
        tick();
        compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL drop_release: got %h expected %h", arb_if.gnt_o, 8'h00); end
        compared++; if (arb_if.timeout_o !== 1'b0) begin mismatched++; $display("FAIL drop_timeout: got %b expected %b", arb_if.timeout_o, 1'b0); end
        tick();
        tick();
        compared++; if (arb_if.gnt_o !== 8'h04) begin mismatched++; $display("FAIL drop_next: got %h expected %h", arb_if.gnt_o, 8'h04); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        arb_if.req_i = 8'h20;
        tick();
        compared++; if (arb_if.gnt_o !== 8'h20) begin mismatched++; $display("FAIL rstmid_gnt5: got %h expected %h", arb_if.gnt_o, 8'h20); end
        repeat (10) tick();
        #2;
        reset_n = 1'b0;
        #1;
        compared++; if (arb_if.gnt_o !== 8'h00) begin mismatched++; $display("FAIL rstmid_async_gnt: got %h expected %h", arb_if.gnt_o, 8'h00); end
        compared++; if (arb_if.busy_o !== 1'b0) begin mismatched++; $display("FAIL rstmid_async_busy: got %b expected %b", arb_if.busy_o, 1'b0); end
        compared++; if (arb_if.gnt_idx_o !== 3'd0) begin mismatched++; $display("FAIL rstmid_idx: got %0d expected %0d", arb_if.gnt_idx_o, 0); end
        arb_if.req_i = 8'hFF;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        compared++; if (arb_if.gnt_o !== 8'h01) begin mismatched++; $display("FAIL rstmid_first: got %h expected %h", arb_if.gnt_o, 8'h01); end
    endtask

    initial begin
        clock             = 1'b0;
        reset_n           = 1'b0;
        compared          = 0;
        mismatched        = 0;
        arb_if.req_i      = '0;
        arb_if.pkt_done_i = '0;
        test_reset();
        test_single();
        test_round_robin(8'h0F, 4);
        test_round_robin(8'hFF, 8);
        test_wrap();
        test_watchdog();
        test_simultaneous();
        test_req_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Per-output-port scheduler for the 8x8 serial router; one instance per output port (8 total).
- Collects requests from the 8 input ports whose decoded 4-bit destination address selects this output.
- Grants one input at a time, round-robin, and holds the grant for the whole packet.
- Drives the crossbar select for this output and enforces a watchdog plus a one-cycle inter-packet gap.

Parameters:
- NUM_IN, 8, number of requesting input ports.
- IDX_W, 3, width of grant index (clog2 of NUM_IN).
- TIMEOUT, 64, maximum cycles a grant may be held without pkt_done; must exceed a full packet (4 header + 10 pad + 32 payload = 46).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_IN  level request per input; high from header decode until that input's packet ends.
- pkt_done_i  in  NUM_IN  one-cycle pulse per input on its last payload bit (frame_n rising).
- gnt_o  out  NUM_IN  one-hot grant, all-zero when idle.
- gnt_idx_o  out  IDX_W  binary index of current/last winner (crossbar select).
- busy_o  out  1  high while a grant is held.
- timeout_o  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt_o=0, gnt_idx_o=0, busy_o=0, timeout_o=0, rr pointer=NUM_IN-1, so input 0 has first priority.
- States: IDLE, GRANT, GAP.
- IDLE: if any req_i is high, pick the first requester scanning from (ptr+1) mod NUM_IN upward with wrap.
  - Register gnt_o/gnt_idx_o, set busy_o, load watchdog=0, go to GRANT.
  - Grant is visible the cycle after the request is sampled (1-cycle latency).
  - No requests: stay in IDLE.
- GRANT:
  - Watchdog increments each cycle.
  - Release when pkt_done_i[winner]=1, or req_i[winner]=0, or watchdog reaches TIMEOUT-1.
  - On release: gnt_o=0, busy_o=0, ptr=winner, go to GAP.
  - Timeout release additionally pulses timeout_o for exactly one cycle.
  - pkt_done_i and req_i of non-winners are ignored in this state.
- GAP: exactly one cycle with no grant, so frameo_n returns high between packets. Then go to IDLE; arbitration resumes the following cycle.
- Simultaneous events:
  - pkt_done and timeout in the same cycle count as a normal release; timeout_o stays 0.
  - A new request arriving in the same cycle as a release waits until IDLE.
- Fairness: with all 8 requesting continuously, grants go 0,1,...,7,0 in order. Each input waits at most 7 packets.
- gnt_idx_o holds its last value in IDLE/GAP; the crossbar qualifies it with busy_o.
- Reset mid-packet: grant drops immediately (async) and ptr returns to NUM_IN-1.
- gnt_o is always one-hot or zero. popcount(gnt_o)>1 is a design error and is asserted against in the RTL.

Decomposition:
- Shared package router_pkg holds:
  - NUM_PORTS=8, PORT_IDX_W=3, HDR_BITS=4, PAD_BITS=10, PAYLOAD_BITS=32.
  - arb_state_t enum {IDLE, GRANT, GAP}.
- One sub-module, rr_pick: combinational rotate-priority-encoder.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, binary index, any_valid.
- The FSM, watchdog counter and pointer register live in router_out_arbiter.

Test Plan:
- Single request: req_i=8'h01 at cycle t, pkt_done_i[0] pulse at t+46 -> gnt_o=8'h01 from t+1 through t+46; GAP at t+47; busy_o=0 from t+47.
- Contention after reset: req_i=8'h0F held, each winner pulses pkt_done 46 cycles after grant -> grant order 0,1,2,3,0; one idle GAP cycle between grants.
- Wrap-around: last winner 6, then req_i=8'h81 -> input 7 granted before input 0.
- Watchdog: req_i=8'h04 held, no pkt_done -> grant revoked after 64 cycles; timeout_o pulses once; next grant goes to the next requester after 2, not 2 again if others request.
- Simultaneous: pkt_done_i[winner] and watchdog expiry on the same cycle -> timeout_o=0; normal GAP then IDLE.
- Reset mid-grant: reset_n low during GRANT -> gnt_o=0 and busy_o=0 asynchronously; after release with req_i=8'hFF -> input 0 granted first.
